// File: rtl/mat_vec_mul_seq.sv
// Stream-fed 4x4 matrix-vector multiplier: loads A (row-major) then x over valid/ready,
// computes y = A*x with one shared MAC (one product per cycle), returns y1..y4 as a stream.
module mat_vec_mul_seq #(
    parameter int N = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_in_valid,
    output logic           o_in_ready,
    input  logic [N-1:0]   i_in_data,
    output logic           o_out_valid,
    input  logic           i_out_ready,
    output logic [2*N+2:0] o_out_data,
    output logic [1:0]     o_out_idx,
    output logic           o_out_last,
    output logic           o_busy
);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

    state_t           r_state;
    logic [4:0]       r_w;
    logic [1:0]       r_row;
    logic [1:0]       r_col;
    logic [N-1:0]     r_a [16];
    logic [N-1:0]     r_x [4];
    logic [2*N+2:0]   r_acc;
    logic [2*N+2:0]   r_y [4];
    logic             r_in_ready;
    logic             r_out_valid;
    logic [2*N+2:0]   r_out_data;
    logic [1:0]       r_out_idx;
    logic             r_out_last;
    logic             r_busy;

    logic [2*N-1:0]   w_prod;
    logic [2*N+2:0]   w_sum;
    logic [1:0]       w_next_idx;

    assign w_prod     = r_a[{r_row, r_col}] * r_x[r_col];
    assign w_sum      = ((r_col == 2'd0) ? '0 : r_acc) + {3'b000, w_prod};
    assign w_next_idx = r_out_idx + 2'd1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_LOAD;
            r_w         <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_acc       <= '0;
            for (int i = 0; i < 16; i++) r_a[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_in_ready <= 1'b1;
                    // in_ready is registered, so the first edge after reset only raises it
                    if (i_in_valid && r_in_ready) begin
                        if (!r_w[4]) r_a[r_w[3:0]] <= i_in_data;
                        else         r_x[r_w[1:0]] <= i_in_data;
                        if (r_w == 5'd19) begin
                            r_state    <= S_COMPUTE;
                            r_w        <= '0;
                            r_row      <= '0;
                            r_col      <= '0;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end else begin
                            r_w <= r_w + 5'd1;
                        end
                    end
                end
                S_COMPUTE: begin
                    r_acc <= w_sum;
                    r_col <= r_col + 2'd1;
                    if (r_col == 2'd3) begin
                        r_y[r_row] <= w_sum;
                        r_row      <= r_row + 2'd1;
                        if (r_row == 2'd3) begin
                            // y[0] was committed three rows ago, so it can be presented now
                            r_state     <= S_OUTPUT;
                            r_out_valid <= 1'b1;
                            r_out_data  <= r_y[0];
                            r_out_idx   <= 2'd0;
                            r_out_last  <= 1'b0;
                        end
                    end
                end
                S_OUTPUT: begin
                    if (r_out_valid && i_out_ready) begin
                        if (r_out_idx == 2'd3) begin
                            r_state     <= S_LOAD;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_idx   <= '0;
                            r_out_last  <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_out_data <= r_y[w_next_idx];
                            r_out_idx  <= w_next_idx;
                            r_out_last <= (w_next_idx == 2'd3);
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_idx   = r_out_idx;
    assign o_out_last  = r_out_last;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_mat_vec_mul_seq.sv
// Directed bench for mat_vec_mul_seq: hand-computed results, latency, backpressure
// and mid-operation reset, checked with immediate assertions.
module tb_mat_vec_mul_seq;

    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N+2:0] out_data;
    logic [1:0]     out_idx;
    logic           out_last;
    logic           busy;

    int tests  = 0;
    int failed = 0;

    logic [N-1:0]   stim [20];
    logic [63:0]    expy [4];

    mat_vec_mul_seq #(.N(N)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in_data  (in_data),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_out_data (out_data),
        .o_out_idx  (out_idx),
        .o_out_last (out_last),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"},  64'(out_data),  64'd0);
        chk({tag, "_out_idx"},   64'(out_idx),   64'd0);
        chk({tag, "_out_last"},  64'(out_last),  64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    // Streams stim[0..19]; with gaps, in_valid is low on every cycle index divisible by 3.
    task automatic load_op(input string tag, input bit gaps, output int cycles);
        int  n;
        int  i;
        bit  acc;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_ready_wait"}, 64'(in_ready), 64'd1);
        i = 0;
        cycles = 0;
        while (i < 20 && cycles < 200) begin
            in_valid = gaps ? ((cycles % 3) != 0) : 1'b1;
            in_data  = stim[i];
            chk({tag, "_no_ovalid_in_load"}, 64'(out_valid), 64'd0);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            cycles++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        chk({tag, "_words"},        64'(i),        64'd20);
        chk({tag, "_busy_after"},   64'(busy),     64'd1);
        chk({tag, "_ready_after"},  64'(in_ready), 64'd0);
    endtask

    task automatic wait_out(input string tag, output int n);
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_out_valid_up"}, 64'(out_valid), 64'd1);
    endtask

    // Consumes 4 results; bp: ready low for 5 cycles, then high on every other cycle.
    task automatic collect(input string tag, input bit bp, output int cycles);
        int k;
        bit rdy;
        bit hs;
        k = 0;
        cycles = 0;
        while (k < 4 && cycles < 100) begin
            rdy = bp ? (cycles >= 5 && (cycles % 2) == 1) : 1'b1;
            out_ready = rdy;
            chk({tag, "_ovalid"},    64'(out_valid), 64'd1);
            chk({tag, "_iready_lo"}, 64'(in_ready),  64'd0);
            chk({tag, "_data"},      64'(out_data),  expy[k]);
            chk({tag, "_idx"},       64'(out_idx),   64'(k));
            chk({tag, "_last"},      64'(out_last),  64'(k == 3));
            hs = out_valid && rdy;
            @(posedge clk); #1;
            if (hs) k++;
            cycles++;
        end
        out_ready = 1'b0;
        chk({tag, "_results"},   64'(k),         64'd4);
        chk({tag, "_iready_up"}, 64'(in_ready),  64'd1);
        chk({tag, "_ovalid_lo"}, 64'(out_valid), 64'd0);
        chk({tag, "_busy_lo"},   64'(busy),      64'd0);
    endtask

    task automatic set_identity();
        stim = '{16'd1, 16'd0, 16'd0, 16'd0,  16'd0, 16'd1, 16'd0, 16'd0,
                 16'd0, 16'd0, 16'd1, 16'd0,  16'd0, 16'd0, 16'd0, 16'd1,
                 16'd1, 16'd2, 16'd3, 16'd4};
        expy = '{64'd1, 64'd2, 64'd3, 64'd4};
    endtask

    initial begin
        int lat;
        int cyc;

        // Reset state
        #2;
        check_all_zero("reset");
        @(posedge clk); #1;
        check_all_zero("reset_held");
        #2 rst = 1'b0;
        chk("ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("ready_after_release", 64'(in_ready), 64'd1);

        // Identity matrix
        set_identity();
        load_op("ident", 1'b0, cyc);
        chk("ident_load_cycles", 64'(cyc), 64'd20);
        wait_out("ident", lat);
        chk("ident_latency", 64'(lat), 64'd16);
        collect("ident", 1'b0, cyc);
        chk("ident_out_cycles", 64'(cyc), 64'd4);

        // Anti-diagonal
        stim = '{16'd0, 16'd0, 16'd0, 16'd1,  16'd0, 16'd0, 16'd1, 16'd0,
                 16'd0, 16'd1, 16'd0, 16'd0,  16'd1, 16'd0, 16'd0, 16'd0,
                 16'd1, 16'd2, 16'd3, 16'd4};
        expy = '{64'd4, 64'd3, 64'd2, 64'd1};
        load_op("anti", 1'b0, cyc);
        wait_out("anti", lat);
        chk("anti_latency", 64'(lat), 64'd16);
        collect("anti", 1'b0, cyc);

        // Mixed matrix with source gaps
        stim = '{16'd1, 16'd0, 16'd1, 16'd0,  16'd0, 16'd1, 16'd0, 16'd1,
                 16'd1, 16'd0, 16'd0, 16'd1,  16'd0, 16'd1, 16'd1, 16'd0,
                 16'd5, 16'd10, 16'd20, 16'd10};
        expy = '{64'd25, 64'd20, 64'd15, 64'd30};
        load_op("mixed", 1'b1, cyc);
        chk("mixed_load_cycles", 64'(cyc), 64'd30);
        wait_out("mixed", lat);
        chk("mixed_latency", 64'(lat), 64'd16);
        collect("mixed", 1'b0, cyc);

        // Full scale
        for (int i = 0; i < 20; i++) stim[i] = 16'hFFFF;
        expy = '{64'h3_FFF8_0004, 64'h3_FFF8_0004, 64'h3_FFF8_0004, 64'h3_FFF8_0004};
        load_op("full", 1'b0, cyc);
        wait_out("full", lat);
        chk("full_bit34", 64'(out_data[2*N+2]), 64'd0);
        collect("full", 1'b0, cyc);

        // Output backpressure (mixed matrix, no gaps)
        stim = '{16'd1, 16'd0, 16'd1, 16'd0,  16'd0, 16'd1, 16'd0, 16'd1,
                 16'd1, 16'd0, 16'd0, 16'd1,  16'd0, 16'd1, 16'd1, 16'd0,
                 16'd5, 16'd10, 16'd20, 16'd10};
        expy = '{64'd25, 64'd20, 64'd15, 64'd30};
        load_op("bp", 1'b0, cyc);
        wait_out("bp", lat);
        collect("bp", 1'b1, cyc);
        chk("bp_out_cycles", 64'(cyc), 64'd12);

        // Reset during COMPUTE, then identity again
        stim = '{16'd9, 16'd9, 16'd9, 16'd9,  16'd9, 16'd9, 16'd9, 16'd9,
                 16'd9, 16'd9, 16'd9, 16'd9,  16'd9, 16'd9, 16'd9, 16'd9,
                 16'd7, 16'd7, 16'd7, 16'd7};
        load_op("abort", 1'b0, cyc);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
        end
        chk("abort_busy_mid", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check_all_zero("abort_rst");
        @(posedge clk); #2;
        rst = 1'b0;
        chk("abort_ready_pre", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("abort_ready_post", 64'(in_ready), 64'd1);
        set_identity();
        load_op("rerun", 1'b0, cyc);
        wait_out("rerun", lat);
        chk("rerun_latency", 64'(lat), 64'd16);
        collect("rerun", 1'b0, cyc);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mat_vec_mul_seq.md
# mat_vec_mul_seq

Sequential, stream-fed counterpart of the combinational 4x4 matrix-vector multiplier. It accepts the 16 matrix elements and 4 vector elements as a serial word stream over a valid/ready handshake. It computes y = A·x with a single shared multiply-accumulate unit, one product per cycle, and returns y1..y4 as a serial result stream. It sits between a narrow operand source (FIFO or bus bridge) and a result consumer, where the 20-word-wide parallel interface is not affordable.

## Interface
- N, default 16: unsigned element width of matrix and vector words.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  source presents a word on in_data.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  N  operand word. Order: a1..a16 row-major (a1..a4 = row 1), then x1..x4.
- out_valid  output  1  result word present on out_data.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  2N+3  result yk, unsigned, same width as the combinational block's y outputs.
- out_idx  output  2  k-1 for the presented yk (0..3).
- out_last  output  1  high together with y4 (out_idx==3).
- busy  output  1  high in COMPUTE and OUTPUT.

## Operation
- State machine with states LOAD, COMPUTE and OUTPUT.
- **LOAD**
  - in_ready=1.
  - A word transfers on a rising edge where in_valid&in_ready.
  - Word counter w runs 0..19. Words 0..15 go to the matrix registers a[w]; words 16..19 go to the vector registers x[w-16].
  - The transfer with w==19 moves the FSM to COMPUTE, clears w, and clears the row/column counters.
  - in_valid low inserts idle cycles with no effect.
- **COMPUTE**
  - in_ready=0.
  - 16 cycles, row r=0..3 outer, column c=0..3 inner.
  - Each edge: acc <= (c==0 ? 0 : acc) + a[4r+c]*x[c].
  - On c==3 the sum is also written to y[r].
  - After the edge with r==3,c==3, the FSM goes to OUTPUT with idx=0.
- **OUTPUT**
  - out_valid=1, out_data=y[idx], out_idx=idx, out_last=(idx==3).
  - An out_valid&out_ready edge advances idx.
  - The handshake on idx==3 returns the FSM to LOAD.
  - out_data, out_idx and out_last are held stable while out_valid&!out_ready.
- **Arithmetic**
  - Unsigned. Product is 2N bits; acc is 2N+3 bits.
  - Overflow is impossible: max 4·(2^N−1)^2 < 2^(2N+2). Bit 2N+2 of out_data is always 0.
- **Matrix reuse:** none. Every operation reloads all 20 words.

## Timing
- **Reset (async, immediate)**
  - State LOAD; w, r, c, idx = 0.
  - acc, y[0..3], a[], x[] = 0.
  - Outputs: in_ready=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0.
  - in_ready rises at the first clk edge after rst deasserts.
- **Latency**
  - With a source that never stalls, 20 input words take 20 cycles.
  - out_valid rises 16 cycles after the edge that accepts the 20th word.
  - With out_ready held high, the 4 results take 4 cycles.
  - in_ready rises on the edge that completes the y4 handshake.
  - Minimum period per operation: 40 cycles.
- **Handshake rules**
  - in_ready and out_valid are never high simultaneously.
  - in_data is ignored when !in_ready.
  - out_ready is ignored when !out_valid.
- **Backpressure:** out_ready low for any number of cycles stalls OUTPUT indefinitely with no data change.
- **Reset mid-operation (any state):** discards partial loads, partial sums and pending results. The next operation starts with word 0 after reset release.
- **busy:** registered. Goes high the cycle after the 20th accept and low the cycle after the y4 handshake.

## Test plan
- **Identity matrix:** stream a = 1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1 and x = 1,2,3,4 with in_valid constant, out_ready=1.
  - Required: out_data 1,2,3,4 with out_idx 0..3 and out_last on the 4th word.
  - out_valid rises exactly 16 cycles after the last input accept.
- **Anti-diagonal:** a = 0,0,0,1, 0,0,1,0, 0,1,0,0, 1,0,0,0 with x = 1,2,3,4.
  - Required: 4,3,2,1.
- **Mixed matrix with source gaps:** a = 1,0,1,0, 0,1,0,1, 1,0,0,1, 0,1,1,0 with x = 5,10,20,10. in_valid low on every third cycle.
  - Required: 25,20,15,30.
  - Input acceptance takes 30 cycles in total.
- **Full scale, N=16:** all 20 words 0xFFFF.
  - Required: every y = 0x3FFF80004, with bit 34 = 0.
- **Output backpressure:** out_ready low for 5 cycles while y1 is presented, then pulsed one cycle in every two.
  - Required: out_data/out_idx held during each stall.
  - No result is lost or duplicated.
  - in_ready rises only after the y4 handshake.
- **Reset mid-operation:** assert rst during COMPUTE at cycle 7, then rerun the identity case.
  - Required: all outputs 0 immediately, in_ready=1 one edge after release.
  - Results are 1,2,3,4, with no residue from the aborted operation.
